// File: rtl/hex_entry_pkg.sv
// hex_entry_pkg: shared button action codes, repeat FSM states and helpers for hex_entry.
package hex_entry_pkg;
  localparam int NUM_BTNS = 5;
  typedef enum logic [2:0] {BTN_NONE, BTN_L, BTN_R, BTN_U, BTN_D, BTN_C} btn_e;
  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} rep_state_e;
  // Bit position of an action code in the {C,D,U,R,L} button vector.
  function automatic logic [2:0] btn_idx(btn_e b);
    return b - 3'd1;
  endfunction
endpackage

// File: rtl/hex_entry_key_repeat.sv
// key_repeat: button edge detect, L>R>U>D>C priority and optional auto-repeat.
// Ports: clk, rst_n (async, active-low); en edit enable; btn {C,D,U,R,L} levels;
// act one-cycle action code. Auto-repeat is built only with HEX_ENTRY_REPEAT_EN.
module key_repeat
  import hex_entry_pkg::*;
#(
  parameter int REPEAT_DELAY  = 25_000_000,
  parameter int REPEAT_PERIOD = 5_000_000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [NUM_BTNS-1:0] btn,
  output btn_e                act
);
  logic [NUM_BTNS-1:0] prev, press;
  btn_e winner;
  // Levels are tracked even while disabled so a button held across en rising needs a re-press.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) prev <= '0;
    else prev <= btn;
  always_comb begin
    press = btn & ~prev & {NUM_BTNS{en}};
    winner = press[0] ? BTN_L : press[1] ? BTN_R : press[2] ? BTN_U :
             press[3] ? BTN_D : press[4] ? BTN_C : BTN_NONE;
  end
`ifdef HEX_ENTRY_REPEAT_EN
  rep_state_e state, nxt_state;
  btn_e hold, nxt_hold;
  logic [31:0] cnt, nxt_cnt, lim;
  logic emit;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      hold <= BTN_NONE;
      cnt <= '0;
    end else begin
      state <= nxt_state;
      hold <= nxt_hold;
      cnt <= nxt_cnt;
    end
  always_comb begin
    nxt_state = state;
    nxt_hold = hold;
    nxt_cnt = cnt;
    emit = 1'b0;
    lim = state == HOLD ? 32'(REPEAT_DELAY) : 32'(REPEAT_PERIOD);
    if (!en) nxt_state = IDLE;
    else if (state == IDLE) begin
      if (winner != BTN_NONE && winner != BTN_C) begin
        nxt_state = HOLD;
        nxt_hold = winner;
        nxt_cnt = '0;
      end
    end else if (!btn[btn_idx(hold)] || (winner != BTN_NONE && winner < hold)) nxt_state = IDLE;
    else if (cnt >= lim - 32'd1) begin
      emit = 1'b1;
      nxt_state = REPEAT;
      nxt_cnt = '0;
    end else nxt_cnt = cnt + 32'd1;
    act = winner != BTN_NONE ? winner : emit ? hold : BTN_NONE;
  end
`else
  always_comb act = winner;
`endif
endmodule

// File: rtl/hex_entry.sv
// hex_entry: button-driven hex digit editor for a bank of registers with a blinking cursor.
// Ports: clk, rst_n (async, active-low); en edit enable; sel register select;
// btn_l/r/u/d/c debounced levels; regs register image (reg k in slice k);
// blink one-hot cursor (0 when disabled); cursor digit index; changed write pulse.
// Define HEX_ENTRY_REPEAT_EN to build hold-to-repeat for L/R/U/D.
module hex_entry
  import hex_entry_pkg::*;
#(
  parameter int NUM_REGS = 2,
  parameter int DIGITS = 8,
  parameter logic [NUM_REGS*DIGITS*4-1:0] INIT = '0,
  parameter int REPEAT_DELAY = 25_000_000,
  parameter int REPEAT_PERIOD = 5_000_000,
  localparam int SW = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1,
  localparam int CW = DIGITS > 1 ? $clog2(DIGITS) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic [SW-1:0]              sel,
  input  logic                       btn_l,
  input  logic                       btn_r,
  input  logic                       btn_u,
  input  logic                       btn_d,
  input  logic                       btn_c,
  output logic [NUM_REGS*DIGITS*4-1:0] regs,
  output logic [DIGITS-1:0]          blink,
  output logic [CW-1:0]              cursor,
  output logic                       changed
);
  localparam int RW = DIGITS * 4;
  btn_e act;
  logic [NUM_REGS*RW-1:0] nxt_regs;
  logic [CW-1:0] nxt_cursor;
  logic [3:0] dig;
  logic wr, sel_ok;
  int base;
  key_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)) u_key (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .btn({btn_c, btn_d, btn_u, btn_r, btn_l}),
    .act(act)
  );
  always_comb begin
    nxt_regs = regs;
    nxt_cursor = cursor;
    wr = 1'b0;
    sel_ok = int'(sel) < NUM_REGS;
    base = int'(sel) * RW + int'(cursor) * 4;
    dig = sel_ok ? regs[base +: 4] : 4'h0;
    if (act == BTN_L) nxt_cursor = cursor == CW'(DIGITS - 1) ? '0 : cursor + 1'b1;
    else if (act == BTN_R) nxt_cursor = cursor == '0 ? CW'(DIGITS - 1) : cursor - 1'b1;
    else if (act != BTN_NONE && sel_ok) begin
      wr = 1'b1;
      if (act == BTN_C) nxt_regs[int'(sel) * RW +: RW] = '0;
      else nxt_regs[base +: 4] = act == BTN_U ? dig + 4'd1 : dig - 4'd1;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      regs <= INIT;
      cursor <= '0;
      changed <= 1'b0;
    end else begin
      regs <= nxt_regs;
      cursor <= nxt_cursor;
      changed <= wr;
    end
  assign blink = en ? DIGITS'(1) << cursor : '0;
endmodule
